cordic_cos_iter: RTL
====================

Name: cordic_cos_iter

Overview:
- Iterative fixed-point CORDIC rotation core. Produces cosine and sine of a signed angle in radians.
- Sits directly upstream of function_evaluation, which issues the angle and consumes cos_out/sin_out to build its floating-point result.
- One rotation micro-step per enabled clock. Uses the same start/done/clk_en handshake style as the custom-instruction datapath.

Parameters:
- ITER, 22, number of CORDIC micro-rotations (legal range 8..30).
- W, 32, datapath width; all angle and result values are signed Q2.(W-2).
- GUARD, 2, extra LSBs carried internally on x/y/z and truncated on output.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- clk_en  input  1  clock enable; when low, all state, including done, is frozen.
- start  input  1  request; sampled only when clk_en=1 and state is IDLE or DONE.
- angle  input  W  signed Q2.30 radians; captured on the accepted start.
- cos_out  output  W  signed Q2.30 cosine; valid while done=1 and held until the next accepted start.
- sin_out  output  W  signed Q2.30 sine; same validity rules as cos_out.
- done  output  1  one-cycle (enabled-cycle) completion pulse.
- busy  output  1  high while in RUN.
- range_err  output  1  valid with done; set when |angle| > pi/2, i.e. angle > 0x6487ED51 or angle < -0x6487ED51.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cos_out=0, sin_out=0, done=0, busy=0, range_err=0.
  - x, y, z and iteration counter i cleared.
  - Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE. All transitions occur only on edges where clk_en=1.
- IDLE/DONE with start=1 (accept):
  - Load x = K_inv = 0x26DD3B6A (0.6072529350*2^30, with GUARD zeros appended), y = 0, z = angle (sign-extended, GUARD zeros).
  - i=0; compute range_err from angle; go to RUN; busy=1, done=0.
- IDLE/DONE with start=0: DONE->IDLE with done=0; IDLE stays IDLE.
- RUN, one micro-rotation per enabled edge, d = (z >= 0) ? +1 : -1:
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*atan_tab[i]
  - Shifts are arithmetic.
- atan_tab[i] = round(atan(2^-i) * 2^(30+GUARD)). ROM is combinational; entry 0 = 0x3243F6A9 before guard extension.
- RUN with i == ITER-1: the final rotation is applied; cos_out/sin_out are registered as x'/y' with GUARD bits truncated (arithmetic, toward -inf); state=DONE, done=1, busy=0.
- Latency: start accepted at enabled edge k -> done=1 after enabled edge k+ITER, for exactly one enabled cycle. Throughput is one result per ITER+1 enabled cycles; back-to-back starts are accepted from DONE.
- start while RUN: ignored, no queuing; angle changes during RUN are ignored.
- clk_en=0 at any point: state, counter, registers and outputs hold. A held done stays high until the next enabled edge.
- Out-of-range angle: rotation still performed and results are not defined; range_err=1 alongside done. range_err clears on the next accept.
- Overflow: x/y magnitudes never exceed 1.0+2^-20 for |angle| <= pi/2, so no saturation logic is provided.

Test Plan:
- Reset mid-RUN: start with angle 0x3243F6A9, drop rst after 5 enabled cycles -> outputs 0, done never pulses, state IDLE; a subsequent start completes normally.
- angle=0, ITER=22 -> done exactly 22 enabled cycles after the accept edge; cos_out within ±1024 LSB of 0x40000000, sin_out within ±1024 of 0, range_err=0.
- angle=0x3243F6A9 (pi/4) -> cos_out and sin_out both within ±1024 of 0x2D413CCD.
- angle=-562209904 (-pi/6) -> cos_out ≈ 929887698, sin_out ≈ -536870912, each ±1024; then immediate back-to-back start from DONE with angle=0x6487ED51 (pi/2) -> cos ≈ 0, sin ≈ 0x40000000, range_err=0.
- clk_en toggled 50% pseudo-randomly during RUN -> done arrives after exactly 22 enabled edges, with identical results to the ungated run; a start pulsed during RUN is ignored.
- angle=0x70000000 -> range_err=1 with done; the next accepted start at angle 0 clears range_err.

Source files
------------

// File: rtl/cordic_cos_iter.sv
// Iterative CORDIC rotation core: cos/sin of a signed Q2.30 angle.
// One micro-rotation per enabled clock, start/done/clk_en handshake.
module cordic_cos_iter #(
  parameter int ITER  = 22,
  parameter int W     = 32,
  parameter int GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [W-1:0] angle,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic         done,
  output logic         busy,
  output logic         range_err
);

  localparam int WI = W + GUARD;
  localparam int IW = $clog2(ITER);
  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  localparam logic signed [WI-1:0] X0 =
    WI'(32'sh26DD3B6A) <<< GUARD;
  localparam logic signed [W-1:0] HALF_PI =
    W'(32'sh6487ED51);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic signed [WI-1:0]   x_q, x_d;
  logic signed [WI-1:0]   y_q, y_d;
  logic signed [WI-1:0]   z_q, z_d;
  logic [IW-1:0]          i_q, i_d;
  logic [W-1:0]           cos_q, cos_d;
  logic [W-1:0]           sin_q, sin_d;
  logic                   rerr_q, rerr_d;

  logic signed [W-1:0]    ang_s;
  logic signed [WI-1:0]   sh_x, sh_y, at;
  logic signed [WI-1:0]   x_r, y_r, z_r;

  // Table held at 2^-32 resolution, rescaled to the internal LSB.
  function automatic logic signed [WI-1:0] atan_rom(
    input logic [IW-1:0] k
  );
    logic [63:0] v;
    case (int'(k))
      0:  v = 64'd3373259426;
      1:  v = 64'd1991351318;
      2:  v = 64'd1052175346;
      3:  v = 64'd534100635;
      4:  v = 64'd268086748;
      5:  v = 64'd134174063;
      6:  v = 64'd67103403;
      7:  v = 64'd33553749;
      8:  v = 64'd16777131;
      9:  v = 64'd8388597;
      10: v = 64'd4194303;
      11: v = 64'd2097152;
      12: v = 64'd1048576;
      13: v = 64'd524288;
      14: v = 64'd262144;
      15: v = 64'd131072;
      16: v = 64'd65536;
      17: v = 64'd32768;
      18: v = 64'd16384;
      19: v = 64'd8192;
      20: v = 64'd4096;
      21: v = 64'd2048;
      22: v = 64'd1024;
      23: v = 64'd512;
      24: v = 64'd256;
      25: v = 64'd128;
      26: v = 64'd64;
      27: v = 64'd32;
      28: v = 64'd16;
      29: v = 64'd8;
      default: v = 64'd0;
    endcase
    return WI'((v << GUARD) >> 2);
  endfunction

  assign ang_s = angle;

  always_comb begin
    sh_x = x_q >>> i_q;
    sh_y = y_q >>> i_q;
    at   = atan_rom(i_q);
    if (z_q[WI-1]) begin
      x_r = x_q + sh_y;
      y_r = y_q - sh_x;
      z_r = z_q + at;
    end else begin
      x_r = x_q - sh_y;
      y_r = y_q + sh_x;
      z_r = z_q - at;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    rerr_d  = rerr_q;
    if (clk_en) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            state_d = S_RUN;
            x_d     = X0;
            y_d     = '0;
            z_d     = WI'(ang_s) <<< GUARD;
            i_d     = '0;
            rerr_d  = (ang_s > HALF_PI) ||
                      (ang_s < -HALF_PI);
          end
        end
        S_RUN: begin
          x_d = x_r;
          y_d = y_r;
          z_d = z_r;
          i_d = i_q + IW'(1);
          if (i_q == LAST) begin
            state_d = S_DONE;
            i_d     = '0;
            cos_d   = x_r[WI-1:GUARD];
            sin_d   = y_r[WI-1:GUARD];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      rerr_q  <= rerr_d;
    end
  end

  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign range_err = rerr_q;

endmodule
